dtag_array: RTL and testbench
=============================

Name: dtag_array

Overview:
- Parametrised N-way set-associative data-cache tag array.
- Successor to the fixed 4-way tag RAM: adds per-line valid bits, registered tag compare with hit/way encode, per-set round-robin victim selection, and a sequenced invalidate-all sweep.
- Sits between the dcache controller and the data RAMs.
- Controller issues lookups and fills, and consumes hit, hit_way and victim_way one cycle after each lookup.

Parameters:
- WAYS, 4: associativity; power of two, >= 2.
- TAG_W, 20: tag width in bits.
- IDX_W, 7: log2 of the number of sets.
- NUM, 1<<IDX_W: number of sets (derived).
- WAY_W, clog2(WAYS): way-number width (derived).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- lk_en  in  1  lookup request.
- lk_index  in  IDX_W  lookup set.
- lk_tag  in  TAG_W  tag to compare.
- lk_vld  out  1  lookup result valid (one cycle after an accepted lk_en).
- hit  out  1  a valid way matched lk_tag.
- hit_way  out  WAY_W  lowest-numbered matching way; 0 on miss.
- multi_hit  out  1  more than one valid way matched (error flag).
- victim_way  out  WAY_W  way to fill on miss.
- wr_en  in  1  tag/valid write.
- wr_index  in  IDX_W  write set.
- wr_way  in  WAY_W  write way.
- wr_tag  in  TAG_W  tag to store.
- wr_valid  in  1  valid bit to store; 0 invalidates the line.
- inv_all  in  1  start invalidate-all sweep (pulse).
- busy  out  1  sweep in progress.
- flush_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Storage
  - tag[WAYS][NUM] is not reset.
  - valid[WAYS][NUM] and rr_ptr[NUM] (WAY_W bits each) are reset.
- Reset (async, rst=1)
  - All valid bits and rr_ptr cleared; FSM goes to IDLE.
  - lk_vld, hit, hit_way, multi_hit, victim_way, busy, flush_done are all 0.
  - Reset asserted mid-sweep aborts it: FSM to IDLE, no flush_done.
- Lookup (IDLE only), 1-cycle latency
  - lk_en sampled at edge N; results registered and visible after edge N, i.e. during cycle N+1.
  - lk_vld=1 for exactly that one cycle; all result outputs hold their last values when lk_vld=0.
  - hit = OR over w of (valid[w][idx] & tag[w][idx]==lk_tag).
  - hit_way = lowest matching w; multi_hit = popcount(matches) > 1.
  - victim_way = lowest-numbered invalid way in the set if any, else rr_ptr[idx]. Computed on every lookup, hit or miss.
- Write (IDLE only)
  - wr_en at edge N sets tag[wr_way][wr_index]=wr_tag and valid=wr_valid.
  - If wr_valid=1: rr_ptr[wr_index] = (wr_way+1) mod WAYS, wrapping naturally in WAY_W bits.
  - wr_valid=0 leaves rr_ptr unchanged.
- Write/lookup collision (same edge, same set): the lookup sees pre-write contents. The next-cycle lookup sees the new contents.
- FSM: IDLE -> SWEEP -> DONE -> IDLE.
  - IDLE: inv_all=1 -> SWEEP, sweep counter cnt=0.
  - SWEEP: busy=1. Each cycle clears valid[all ways][cnt] and rr_ptr[cnt], then cnt++. Exactly NUM cycles; after clearing set NUM-1 -> DONE.
  - DONE: flush_done=1 for one cycle, busy=0 -> IDLE.
- While busy:
  - lk_en and wr_en are ignored: no lk_vld, no array or rr_ptr change.
  - inv_all is ignored.
- inv_all, lk_en and wr_en asserted together in IDLE:
  - The write and the lookup complete at that edge.
  - The sweep starts at the same edge and later clears the written line.

Test Plan:
- Reset then lookup idx 5, tag 0x12345 -> next cycle lk_vld=1, hit=0, victim_way=0, multi_hit=0.
- Write idx 5 way 2 tag 0xABCDE valid=1; lookup idx 5 tag 0xABCDE next cycle -> hit=1, hit_way=2, victim_way=0 (way 0 invalid).
- Fill idx 9 ways 0,1,2,3 in order (tags 1..4); lookup idx 9 tag 7 -> hit=0, victim_way=0 (rr_ptr wrapped 3->0). Write way 1 tag 8 -> lookup victim_way=2.
- Same tag 0x55 written valid into ways 1 and 3 of idx 0; lookup 0x55 -> hit=1, hit_way=1, multi_hit=1.
- Lookup and write to idx 3 at the same edge -> lookup reports old contents; repeat lookup -> new contents.
- Populate sets 0 and 127; pulse inv_all -> busy=1 for exactly 128 cycles, lk_en/wr_en mid-sweep produce no lk_vld and no change, then flush_done pulses once. Subsequent lookups miss with victim_way=0. A second run with rst pulsed at sweep cycle 40 -> busy=0 immediately, no flush_done.

Source files
------------

// File: rtl/dtag_array.sv
// N-way set-associative data-cache tag array with per-line valid bits,
// registered hit/way encode, per-set round-robin victims and an invalidate-all sweep.
module dtag_way #(
  parameter int TAG_W = 20,
  parameter int IDX_W = 7,
  parameter int NUM   = 1 << IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             clr,
  input  logic [IDX_W-1:0] clr_index,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             match,
  output logic             vld
);
  logic [TAG_W-1:0] tag_mem [NUM];
  logic [NUM-1:0]   valid;

  // Tags carry no reset; a line is only meaningful while its valid bit is set.
  always_ff @(posedge clk) begin
    if (we) tag_mem[wr_index] <= wr_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      valid <= '0;
    else if (clr) valid[clr_index] <= 1'b0;
    else if (we)  valid[wr_index]  <= wr_valid;
  end

  assign vld   = valid[rd_index];
  assign match = vld && (tag_mem[rd_index] == rd_tag);
endmodule

module dtag_array #(
  parameter int WAYS  = 4,
  parameter int TAG_W = 20,
  parameter int IDX_W = 7,
  parameter int NUM   = 1 << IDX_W,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_en,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_vld,
  output logic             hit,
  output logic [WAY_W-1:0] hit_way,
  output logic             multi_hit,
  output logic [WAY_W-1:0] victim_way,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [WAY_W-1:0] wr_way,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  logic             inv_all,
  output logic             busy,
  output logic             flush_done
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t                      state, state_nxt;
  logic [IDX_W-1:0]            cnt, cnt_nxt;
  logic                        idle, lk_go, wr_go, clr;
  logic [WAYS-1:0]             match, vset;
  logic [NUM-1:0][WAY_W-1:0]   rr_ptr;
  logic [WAY_W-1:0]            hit_way_d, vic_d;
  logic [WAY_W:0]              nmatch;

  assign idle  = (state == IDLE);
  assign lk_go = idle && lk_en;
  assign wr_go = idle && wr_en;
  assign clr   = (state == SWEEP);

  genvar g;
  generate
    for (g = 0; g < WAYS; g++) begin : g_way
      dtag_way #(.TAG_W(TAG_W), .IDX_W(IDX_W), .NUM(NUM)) u_way (
        .clk       (clk),
        .rst       (rst),
        .we        (wr_go && (wr_way == WAY_W'(g))),
        .clr       (clr),
        .clr_index (cnt),
        .wr_index  (wr_index),
        .wr_tag    (wr_tag),
        .wr_valid  (wr_valid),
        .rd_index  (lk_index),
        .rd_tag    (lk_tag),
        .match     (match[g]),
        .vld       (vset[g])
      );
    end
  endgenerate

  // Scan high-to-low so the lowest-numbered way wins both encodes.
  always_comb begin
    hit_way_d = '0;
    vic_d     = rr_ptr[lk_index];
    nmatch    = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i]) hit_way_d = WAY_W'(i);
      if (!vset[i]) vic_d     = WAY_W'(i);
      nmatch = nmatch + {{WAY_W{1'b0}}, match[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_vld     <= 1'b0;
      hit        <= 1'b0;
      hit_way    <= '0;
      multi_hit  <= 1'b0;
      victim_way <= '0;
    end else begin
      lk_vld <= lk_go;
      if (lk_go) begin
        hit        <= |match;
        hit_way    <= hit_way_d;
        multi_hit  <= (nmatch > (WAY_W+1)'(1));
        victim_way <= vic_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   rr_ptr <= '0;
    else if (clr)              rr_ptr[cnt] <= '0;
    else if (wr_go && wr_valid) rr_ptr[wr_index] <= wr_way + WAY_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (inv_all) begin
        state_nxt = SWEEP;
        cnt_nxt   = '0;
      end
      SWEEP: begin
        cnt_nxt = cnt + IDX_W'(1);
        if (cnt == IDX_W'(NUM - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state == SWEEP);
  assign flush_done = (state == DONE);
endmodule

// File: tb/tb_dtag_array.sv
// Randomized and directed bench for dtag_array against a set/way array model.
module tb_dtag_array;
  localparam int WAYS = 4, TAG_W = 20, IDX_W = 7, NUM = 128, WAY_W = 2;

  logic             clk, rst;
  logic             lk_en, lk_vld, hit, multi_hit, wr_en, wr_valid, inv_all, busy, flush_done;
  logic [IDX_W-1:0] lk_index, wr_index;
  logic [TAG_W-1:0] lk_tag, wr_tag;
  logic [WAY_W-1:0] hit_way, victim_way, wr_way;

  dtag_array #(.WAYS(WAYS), .TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .lk_en(lk_en), .lk_index(lk_index), .lk_tag(lk_tag),
    .lk_vld(lk_vld), .hit(hit), .hit_way(hit_way), .multi_hit(multi_hit), .victim_way(victim_way),
    .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way), .wr_tag(wr_tag), .wr_valid(wr_valid),
    .inv_all(inv_all), .busy(busy), .flush_done(flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // reference model: plain per-set arrays plus the last reported lookup result
  int  m_tag [WAYS][NUM];
  bit  m_val [WAYS][NUM];
  int  m_rr  [NUM];
  bit  e_hit, e_multi;
  int  e_way, e_vic;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM; i++) begin
      m_rr[i] = 0;
      for (int w = 0; w < WAYS; w++) m_val[w][i] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    lk_en = 0; wr_en = 0; inv_all = 0; wr_valid = 0;
    lk_index = '0; lk_tag = '0; wr_index = '0; wr_way = '0; wr_tag = '0;
  endtask

  task automatic op(bit lk, int li, int lt, bit we, int wi, int ww, int wt, bit wv, bit inv = 0);
    int nm;
    if (lk) begin
      nm = 0; e_way = 0;
      for (int w = 0; w < WAYS; w++)
        if (m_val[w][li] && m_tag[w][li] == lt) begin
          if (nm == 0) e_way = w;
          nm++;
        end
      e_hit = (nm > 0); e_multi = (nm > 1);
      e_vic = m_rr[li];
      for (int w = WAYS - 1; w >= 0; w--) if (!m_val[w][li]) e_vic = w;
    end
    if (we) begin
      m_tag[ww][wi] = lt == lt ? wt : wt;
      m_val[ww][wi] = wv;
      if (wv) m_rr[wi] = (ww + 1) % WAYS;
    end
    if (inv) model_clear();
    lk_en = lk; lk_index = IDX_W'(li); lk_tag = TAG_W'(lt);
    wr_en = we; wr_index = IDX_W'(wi); wr_way = WAY_W'(ww); wr_tag = TAG_W'(wt); wr_valid = wv;
    inv_all = inv;
    cyc();
    idle_inputs();
    chk("lk_vld", lk_vld, lk);
    chk("hit", hit, e_hit);
    chk("hit_way", hit_way, e_way);
    chk("multi_hit", multi_hit, e_multi);
    chk("victim_way", victim_way, e_vic);
    chk("busy", busy, inv);
  endtask

  // mid-sweep valid writes; each must be dropped
  int q_idx[$], q_tag[$];

  task automatic run_sweep(int exp_len);
    int n = 0;
    while (busy && n < 300) begin
      chk("flush_early", flush_done, 1'b0);
      n++;
      lk_en = $urandom_range(0, 1); lk_index = IDX_W'($urandom_range(0, NUM - 1));
      lk_tag = TAG_W'($urandom);
      wr_en = $urandom_range(0, 1); wr_index = IDX_W'($urandom_range(0, NUM - 1));
      wr_way = WAY_W'($urandom_range(0, WAYS - 1)); wr_tag = TAG_W'($urandom); wr_valid = 1'b1;
      inv_all = $urandom_range(0, 1);
      if (wr_en) begin q_idx.push_back(int'(wr_index)); q_tag.push_back(int'(wr_tag)); end
      cyc();
      chk("sweep_lk_vld", lk_vld, 1'b0);
    end
    idle_inputs();
    chk("busy_len", n, exp_len);
    chk("flush_pulse", flush_done, 1'b1);
    cyc();
    chk("flush_once", flush_done, 1'b0);
    chk("busy_after", busy, 1'b0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < NUM; i++) for (int w = 0; w < WAYS; w++) m_tag[w][i] = 0;
    model_clear();
    e_hit = 0; e_multi = 0; e_way = 0; e_vic = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lk_vld", lk_vld, 0); chk("rst_hit", hit, 0); chk("rst_hit_way", hit_way, 0);
    chk("rst_multi", multi_hit, 0); chk("rst_victim", victim_way, 0);
    chk("rst_busy", busy, 0); chk("rst_flush", flush_done, 0);
    rst = 1'b0;
    cyc();

    op(1, 5, 'h12345, 0, 0, 0, 0, 0);
    op(0, 0, 0, 1, 5, 2, 'hABCDE, 1);
    op(1, 5, 'hABCDE, 0, 0, 0, 0, 0);
    chk("tp2_way", hit_way, 2); chk("tp2_vic", victim_way, 0);

    for (int w = 0; w < WAYS; w++) op(0, 0, 0, 1, 9, w, w + 1, 1);
    op(1, 9, 7, 0, 0, 0, 0, 0);
    chk("tp3_wrap", victim_way, 0);
    op(0, 0, 0, 1, 9, 1, 8, 1);
    op(1, 9, 7, 0, 0, 0, 0, 0);
    chk("tp3_rr", victim_way, 2);

    op(0, 0, 0, 1, 0, 1, 'h55, 1);
    op(0, 0, 0, 1, 0, 3, 'h55, 1);
    op(1, 0, 'h55, 0, 0, 0, 0, 0);
    chk("tp4_multi", multi_hit, 1); chk("tp4_way", hit_way, 1);

    op(1, 3, 'h99, 1, 3, 0, 'h99, 1);
    chk("coll_old", hit, 0);
    op(1, 3, 'h99, 0, 0, 0, 0, 0);
    chk("coll_new", hit, 1);

    // invalidate line by write with valid=0
    op(0, 0, 0, 1, 3, 0, 'h99, 0);
    op(1, 3, 'h99, 0, 0, 0, 0, 0);

    for (int k = 0; k < 400; k++)
      op($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
         $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, WAYS - 1),
         $urandom_range(0, 3), $urandom_range(0, 3) != 0);

    // full sweep after populating the first and last sets
    for (int w = 0; w < WAYS; w++) begin
      op(0, 0, 0, 1, 0, w, 'h100 + w, 1);
      op(0, 0, 0, 1, NUM - 1, w, 'h200 + w, 1);
    end
    op(0, 0, 0, 0, 0, 0, 0, 0, 1);
    run_sweep(NUM);
    for (int w = 0; w < WAYS; w++) begin
      op(1, 0, 'h100 + w, 0, 0, 0, 0, 0);
      op(1, NUM - 1, 'h200 + w, 0, 0, 0, 0, 0);
    end
    while (q_idx.size() > 0) begin
      op(1, q_idx.pop_front(), q_tag.pop_front(), 0, 0, 0, 0, 0);
      chk("sweep_wr_dropped", hit, 0);
    end

    // lookup, write and sweep start on the same edge
    op(0, 0, 0, 1, 4, 0, 'h44, 1);
    op(1, 4, 'h44, 1, 4, 1, 'h45, 1, 1);
    chk("combo_hit", hit, 1);
    run_sweep(NUM);
    q_idx.delete(); q_tag.delete();
    op(1, 4, 'h45, 0, 0, 0, 0, 0);

    // reset during a sweep aborts it without flush_done
    op(0, 0, 0, 1, 6, 0, 'h66, 1);
    op(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (39) cyc();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0); chk("abort_flush", flush_done, 0); chk("abort_lk_vld", lk_vld, 0);
    model_clear();
    e_hit = 0; e_multi = 0; e_way = 0; e_vic = 0;
    cyc();
    rst = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 200; k++) begin
        cyc();
        if (flush_done || busy) seen++;
      end
      chk("abort_no_flush", seen, 0);
    end
    op(1, 6, 'h66, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
